// File: rtl/cat_rec_mac_engine.sv
// cat_rec_mac_engine: streams pixel words and weight rows, 3-lane MAC, bias, cat decision.
// Optional: define ACC_SATURATE_EN for saturating adds (default: two's-complement wrap).
module cat_rec_mac_engine #(
  parameter int AMBA_WORD        = 24,
  parameter int PIXEL_WIDTH      = 8,
  parameter int WEIGHT_PRECISION = 5,
  parameter int ADDR_DEPTH       = 12,
  parameter int ITERATION        = 4096,
  parameter int RESULT_WIDTH     = 32,
  parameter int BIAS_WIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIAS_WIDTH-1:0]         bias,
  output logic [ADDR_DEPTH:0]           pix_addr,
  input  logic [AMBA_WORD-1:0]          pix_data,
  output logic [ADDR_DEPTH:0]           w_addr,
  input  logic [3*WEIGHT_PRECISION-1:0] w_data,
  output logic                          busy,
  output logic                          done_iteration,
  output logic [RESULT_WIDTH-1:0]       current_result,
  output logic                          done,
  output logic                          cat_rec_out
);

  localparam int AW  = ADDR_DEPTH + 1;
  localparam int PW  = PIXEL_WIDTH;
  localparam int WP  = WEIGHT_PRECISION;
  localparam int RW  = RESULT_WIDTH;
  localparam int PRW = PW + 1 + WP;
  localparam int WW  = (RW > BIAS_WIDTH ? RW : BIAS_WIDTH) + 2;
  localparam logic [AW-1:0] LAST = AW'(ITERATION);

`ifdef ACC_SATURATE_EN
  localparam logic signed [RW-1:0] MAX_R = {1'b0, {(RW-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_R = {1'b1, {(RW-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_BIAS,
    S_DONE
  } state_t;

  state_t state, nxt;
  logic   accept;
  logic   valid_d;

  logic signed [RW-1:0]         acc;
  logic signed [BIAS_WIDTH-1:0] bias_q;
  logic signed [RW-1:0]         acc_nxt;
  logic signed [RW-1:0]         fin;

  logic signed [PW:0]     p;
  logic signed [WP-1:0]   wt;
  logic signed [PRW-1:0]  prod;
  logic signed [WW-1:0]   sum;

  function automatic logic signed [RW-1:0] fit(
    input logic signed [WW-1:0] v
  );
`ifdef ACC_SATURATE_EN
    if (v > WW'(MAX_R)) return MAX_R;
    if (v < WW'(MIN_R)) return MIN_R;
`endif
    return v[RW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          nxt    = S_FETCH;
          accept = 1'b1;
        end
      end
      S_FETCH: if (pix_addr == LAST) nxt = S_DRAIN;
      S_DRAIN: nxt = S_BIAS;
      S_BIAS:  nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  // Slot 0 sits in the LSBs; pixels are unsigned, weights signed.
  always_comb begin
    p    = '0;
    wt   = '0;
    prod = '0;
    sum  = WW'(acc);
    for (int i = 0; i < 3; i++) begin
      p    = signed'({1'b0, pix_data[i*PW +: PW]});
      wt   = signed'(w_data[i*WP +: WP]);
      prod = PRW'(p) * PRW'(wt);
      sum  = sum + WW'(prod);
    end
    acc_nxt = fit(sum);
  end

  assign fin = fit(WW'(acc) + WW'(bias_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_addr       <= AW'(1);
      w_addr         <= '0;
      valid_d        <= 1'b0;
      acc            <= '0;
      bias_q         <= '0;
      busy           <= 1'b0;
      done_iteration <= 1'b0;
      current_result <= '0;
      done           <= 1'b0;
      cat_rec_out    <= 1'b0;
    end else begin
      done_iteration <= 1'b0;
      valid_d        <= (state == S_FETCH);
      if (state == S_FETCH && pix_addr != LAST) begin
        pix_addr <= pix_addr + AW'(1);
        w_addr   <= w_addr + AW'(1);
      end
      if (valid_d) begin
        acc            <= acc_nxt;
        current_result <= acc_nxt;
      end
      if (state == S_DRAIN) done_iteration <= 1'b1;
      if (state == S_BIAS) begin
        current_result <= fin;
        cat_rec_out    <= !fin[RW-1] && (fin != '0);
      end
      if (state == S_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (accept) begin
        bias_q         <= bias;
        acc            <= '0;
        current_result <= '0;
        cat_rec_out    <= 1'b0;
        pix_addr       <= AW'(1);
        w_addr         <= '0;
        busy           <= 1'b1;
        done           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cat_rec_mac_engine.sv
// Directed + randomized bench for cat_rec_mac_engine at ITERATION=4.
// A second instance with RESULT_WIDTH=12 exercises wrap/saturation.
module tb_cat_rec_mac_engine;

  localparam int IT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] bias = '0;
  logic [12:0] pix_addr, w_addr, pix_addr2, w_addr2;
  logic [23:0] pix_data = '0;
  logic [14:0] w_data = '0;
  logic        busy, done_iteration, done, cat;
  logic [31:0] cr;
  logic        busy2, di2, done2, cat2;
  logic [11:0] cr2;

  logic [23:0] pmem [16];
  logic [14:0] wmem [16];

  int checks = 0;
  int failures = 0;
  int dcyc, dicyc, dicnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pix_data <= pmem[pix_addr[3:0]];
    w_data   <= wmem[w_addr[3:0]];
  end

  cat_rec_mac_engine #(.ITERATION(IT)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done_iteration(done_iteration),
    .current_result(cr), .done(done), .cat_rec_out(cat)
  );

  cat_rec_mac_engine #(.ITERATION(IT), .RESULT_WIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .start(start2), .bias(16'd0),
    .pix_addr(pix_addr2), .pix_data(24'hFFFFFF),
    .w_addr(w_addr2), .w_data(15'h3DEF),
    .busy(busy2), .done_iteration(di2),
    .current_result(cr2), .done(done2), .cat_rec_out(cat2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
             tag, obs, obs, exp, exp);
    end
  endtask

  task automatic load(input logic [23:0] pv, input logic [14:0] wv);
    for (int i = 0; i < 16; i++) begin
      pmem[i] = pv;
      wmem[i] = wv;
    end
  endtask

  // Dot product straight from the arithmetic definition.
  function automatic longint model(input int b);
    longint s = 0;
    logic signed [4:0] t;
    for (int a = 1; a <= IT; a++)
      for (int k = 0; k < 3; k++) begin
        t = wmem[a-1][k*5 +: 5];
        s += longint'(pmem[a][k*8 +: 8]) * longint'(t);
      end
    return s + b;
  endfunction

  task automatic run(input int b, input int extra_at);
    @(negedge clk);
    bias  = 16'(b);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("done_drop", {31'b0, done}, 32'd0);
    dcyc = -1; dicyc = -1; dicnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      start = (c == extra_at);
      if (done_iteration) begin
        dicnt++;
        dicyc = c;
      end
      if (done) begin
        dcyc = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int b;
    longint e;
    load(24'h010101, 15'h0421);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_addr", {19'b0, pix_addr}, 32'd1);
    chk("rst_w_addr", {19'b0, w_addr}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", cr, 32'd0);
    chk("rst_cat", {31'b0, cat}, 32'd0);
    chk("rst_di", {31'b0, done_iteration}, 32'd0);
    @(negedge clk) rst = 1'b1;

    run(0, -1);
    chk("t1_result", cr, 32'd12);
    chk("t1_cat", {31'b0, cat}, 32'd1);
    chk("t1_done_cycle", dcyc, 32'd7);
    chk("t1_di_cycle", dicyc, 32'd5);
    chk("t1_di_count", dicnt, 32'd1);
    chk("t1_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_hold_done", {31'b0, done}, 32'd1);
    chk("t1_hold_result", cr, 32'd12);

    load(24'hFFFFFF, 15'h4210);
    run(0, -1);
    chk("t2_result", cr, -32'sd48960);
    chk("t2_cat", {31'b0, cat}, 32'd0);

    load(24'h000001, 15'h0002);
    run(-8, -1);
    chk("t3_zero_result", cr, 32'd0);
    chk("t3_zero_cat", {31'b0, cat}, 32'd0);
    run(-7, -1);
    chk("t3_one_result", cr, 32'd1);
    chk("t3_one_cat", {31'b0, cat}, 32'd1);

    load(24'h010101, 15'h0421);
    run(0, 2);
    chk("t4_ignored_result", cr, 32'd12);
    chk("t4_ignored_cycle", dcyc, 32'd7);
    run(0, -1);
    chk("t4_restart_result", cr, 32'd12);

    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_pix_addr", {19'b0, pix_addr}, 32'd1);
    chk("t5_w_addr", {19'b0, w_addr}, 32'd0);
    chk("t5_result", cr, 32'd0);
    chk("t5_done", {31'b0, done}, 32'd0);
    chk("t5_cat", {31'b0, cat}, 32'd0);
    @(negedge clk) rst = 1'b1;
    run(0, -1);
    chk("t5_rerun_result", cr, 32'd12);

    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int c = 0; c < 20 && !done2; c++) @(negedge clk);
    chk("t6_done", {31'b0, done2}, 32'd1);
`ifdef ACC_SATURATE_EN
    chk("t6_result", {20'b0, cr2}, 32'd2047);
`else
    chk("t6_result", {20'b0, cr2}, 32'd844);
`endif
    chk("t6_cat", {31'b0, cat2}, 32'd1);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 16; i++) begin
        pmem[i] = 24'($urandom);
        wmem[i] = 15'($urandom);
      end
      b = int'($urandom_range(0, 40000)) - 20000;
      e = model(b);
      run(b, -1);
      chk("rnd_result", cr, 32'(e));
      chk("rnd_cat", {31'b0, cat}, {31'b0, e > 0});
      chk("rnd_done_cycle", dcyc, 32'd7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
